// File: rtl/spike_aer_pkg.sv
// spike_aer_pkg: shared defaults, event word layout and priority-encoder helper for the AER encoder
package spike_aer_pkg;
   localparam int N_DEF     = 4;
   localparam int TS_W_DEF  = 8;
   localparam int DEPTH_DEF = 8;
   localparam int MAX_N     = 256;

   // Address width for n neurons; a single neuron still gets a 1-bit address
   function automatic int aw_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Event word is {addr, ts}: address in the upper aw bits, timestamp in the lower ts_w bits
   function automatic int ev_w(input int aw, input int ts_w);
      return aw + ts_w;
   endfunction

   localparam int AW_DEF   = aw_of(N_DEF);
   localparam int EV_W_DEF = ev_w(AW_DEF, TS_W_DEF);

   // Index of the lowest set bit; callers zero-extend their vector to MAX_N bits
   function automatic int lsb_index(input logic [MAX_N-1:0] v);
      for (int i = 0; i < MAX_N; i++)
         if (v[i]) return i;
      return 0;
   endfunction
endpackage

// File: rtl/aer_event_fifo.sv
// aer_event_fifo: synchronous event FIFO with full/empty/count; head reads as zero when empty
module aer_event_fifo
   import spike_aer_pkg::*;
#(
   parameter int W     = EV_W_DEF,
   parameter int DEPTH = DEPTH_DEF,
   localparam int PW   = aw_of(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);
   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wptr, rptr;
   logic          do_push, do_pop;

   assign full    = count == CW'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = empty ? '0 : mem[rptr];

   // Storage array: written only on an accepted push
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end

   // Pointers and occupancy; full is judged on the pre-edge count so a pop never frees a same-edge slot
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
         if (do_pop) rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder: captures spike vectors per timestep and serialises them into {addr, ts} AER events
module spike_aer_encoder
   import spike_aer_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int TS_W  = TS_W_DEF,
   parameter int DEPTH = DEPTH_DEF,
   localparam int AW   = aw_of(N)
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            enable,
   input  logic [N-1:0]    spikes_in,
   input  logic            clear_overflow,
   output logic            aer_valid,
   input  logic            aer_ready,
   output logic [AW-1:0]   aer_addr,
   output logic [TS_W-1:0] aer_ts,
   output logic            overflow
);
   localparam int EW = ev_w(AW, TS_W);
   localparam int CW = $clog2(DEPTH + 1);

   logic [TS_W-1:0] ts_cnt, pend_ts;
   logic [N-1:0]    pending;
   logic [AW-1:0]   idx;
   logic [EW-1:0]   din, dout;
   logic [CW-1:0]   fifo_count;
   logic            full, empty, push, pop;

   assign idx       = AW'(lsb_index(MAX_N'(pending)));
   assign din       = {idx, pend_ts};
   assign push      = |pending && !full;
   assign aer_valid = !empty;
   assign pop       = aer_ready && fifo_count != '0;
   assign aer_addr  = dout[TS_W +: AW];
   assign aer_ts    = dout[TS_W-1:0];

   // Timestep counter, pending-vector capture/scan and sticky overflow (set beats clear)
   always_ff @(posedge clk) begin
      if (reset) begin
         ts_cnt   <= '0;
         pending  <= '0;
         pend_ts  <= '0;
         overflow <= 1'b0;
      end else begin
         if (enable) ts_cnt <= ts_cnt + 1'b1;
         if (enable && pending == '0) begin
            pending <= spikes_in;
            pend_ts <= ts_cnt;
         end else if (push) begin
            pending <= pending & (pending - 1'b1);
         end
         if (enable && |pending && |spikes_in) overflow <= 1'b1;
         else if (clear_overflow) overflow <= 1'b0;
      end
   end

   aer_event_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (din),
      .dout  (dout),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );
endmodule

// File: tb/tb_spike_aer_encoder.sv
// tb_spike_aer_encoder: directed self-checking bench for the spike AER encoder
module tb_spike_aer_encoder;
   import spike_aer_pkg::*;
   localparam int N = 4, TS_W = 8, DEPTH = 8, AW = aw_of(N);

   logic            clk = 1'b0, reset = 1'b1, enable = 1'b0, clear_overflow = 1'b0, aer_ready = 1'b0;
   logic [N-1:0]    spikes_in = '0;
   logic            aer_valid, overflow;
   logic [AW-1:0]   aer_addr;
   logic [TS_W-1:0] aer_ts;
   int              n_chk = 0, n_fail = 0;
   logic            seen = 1'b0;

   always #5 clk = ~clk;

   spike_aer_encoder #(.N(N), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .spikes_in      (spikes_in),
      .clear_overflow (clear_overflow),
      .aer_valid      (aer_valid),
      .aer_ready      (aer_ready),
      .aer_addr       (aer_addr),
      .aer_ts         (aer_ts),
      .overflow       (overflow)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ev(input string tag, input logic v, input logic [AW-1:0] a, input logic [TS_W-1:0] t);
      chk({tag, ".valid"}, 32'(aer_valid), 32'(v));
      chk({tag, ".addr"}, 32'(aer_addr), 32'(a));
      chk({tag, ".ts"}, 32'(aer_ts), 32'(t));
   endtask

   initial begin
      tick();
      tick();
      reset = 1'b0;
      chk_ev("rst", 1'b0, '0, '0);
      chk("rst.ovf", 32'(overflow), 0);

      aer_ready = 1'b1;
      enable = 1'b1; spikes_in = 4'b1010;
      tick();
      enable = 1'b0; spikes_in = '0;
      chk("s1.edge_k", 32'(aer_valid), 0);
      tick();
      chk_ev("s1.ev0", 1'b1, 2'd1, 8'd0);
      tick();
      chk_ev("s1.ev1", 1'b1, 2'd3, 8'd0);
      tick();
      chk("s1.empty", 32'(aer_valid), 0);
      chk("s1.ovf", 32'(overflow), 0);

      reset = 1'b1; aer_ready = 1'b0;
      tick();
      reset = 1'b0;
      for (int v = 0; v < 3; v++) begin
         enable = 1'b1; spikes_in = 4'b1111;
         tick();
         enable = 1'b0; spikes_in = '0;
         repeat (9) tick();
      end
      chk_ev("s2.full_head", 1'b1, 2'd0, 8'd0);
      chk("s2.ovf", 32'(overflow), 0);
      aer_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         chk_ev($sformatf("s2.ev%0d", i), 1'b1, AW'(i % 4), TS_W'(i / 4));
         tick();
      end
      chk("s2.drained", 32'(aer_valid), 0);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      enable = 1'b1; spikes_in = 4'b1111;
      tick();
      spikes_in = 4'b0001;
      tick();
      enable = 1'b0; spikes_in = '0;
      chk("s3.ovf_set", 32'(overflow), 1);
      for (int i = 0; i < 4; i++) begin
         chk_ev($sformatf("s3.a%0d", i), 1'b1, AW'(i), 8'd0);
         tick();
      end
      chk("s3.dropped", 32'(aer_valid), 0);
      chk("s3.sticky", 32'(overflow), 1);
      enable = 1'b1; spikes_in = 4'b0010;
      tick();
      enable = 1'b0; spikes_in = '0;
      tick();
      chk_ev("s3.next", 1'b1, 2'd1, 8'd2);
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      chk("s3.clear", 32'(overflow), 0);
      chk("s3.next_gone", 32'(aer_valid), 0);
      enable = 1'b1; spikes_in = 4'b0011;
      tick();
      spikes_in = 4'b0001; clear_overflow = 1'b1;
      tick();
      enable = 1'b0; spikes_in = '0; clear_overflow = 1'b0;
      chk("s3.set_wins", 32'(overflow), 1);
      chk_ev("s3.w0", 1'b1, 2'd0, 8'd3);
      tick();
      chk_ev("s3.w1", 1'b1, 2'd1, 8'd3);
      tick();
      chk("s3.w_empty", 32'(aer_valid), 0);
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      chk("s3.clear2", 32'(overflow), 0);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      enable = 1'b1; spikes_in = '0;
      repeat (256) begin
         tick();
         if (aer_valid !== 1'b0) seen = 1'b1;
      end
      chk("s4.quiet", 32'(seen), 0);
      chk("s4.ovf", 32'(overflow), 0);
      spikes_in = 4'b0100;
      tick();
      enable = 1'b0; spikes_in = '0;
      chk("s4.load_edge", 32'(aer_valid), 0);
      tick();
      chk_ev("s4.wrap", 1'b1, 2'd2, 8'd0);
      tick();
      chk("s4.single", 32'(aer_valid), 0);

      reset = 1'b1;
      tick();
      reset = 1'b0; aer_ready = 1'b0;
      enable = 1'b1; spikes_in = 4'b1111;
      tick();
      spikes_in = 4'b0001;
      tick();
      enable = 1'b0; spikes_in = '0;
      tick();
      chk("s5.pre_valid", 32'(aer_valid), 1);
      chk("s5.pre_ovf", 32'(overflow), 1);
      reset = 1'b1; enable = 1'b1; spikes_in = 4'b1111;
      tick();
      reset = 1'b0; enable = 1'b0; spikes_in = '0;
      chk_ev("s5.after_rst", 1'b0, '0, '0);
      chk("s5.ovf", 32'(overflow), 0);
      tick();
      chk("s5.no_residue", 32'(aer_valid), 0);
      enable = 1'b1; spikes_in = 4'b0001;
      tick();
      enable = 1'b0; spikes_in = '0;
      tick();
      chk_ev("s5.ev", 1'b1, 2'd0, 8'd0);
      tick();
      chk_ev("s5.hold", 1'b1, 2'd0, 8'd0);
      aer_ready = 1'b1;
      tick();
      chk("s5.done", 32'(aer_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/spike_aer_encoder.md
SPIKE_AER_ENCODER -- requirements
Module: spike_aer_encoder

Interface
REQ-001 SHALL have parameter N, default 4: number of spike lines, one per neuron of the driving layer.
REQ-002 SHALL have parameter TS_W, default 8: width of the timestep counter and event timestamp.
REQ-003 SHALL have parameter DEPTH, default 8, a power of two: number of event FIFO entries.
REQ-004 SHALL have derived constant AW = clog2(N), minimum 1: event address width.
REQ-005 clk  input  1  single clock; every register in the block is updated on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  timestep strobe; spikes_in is sampled on each edge where it is high.
REQ-008 spikes_in  input  N  output spike vector from the neuron layer; bit i is neuron i.
REQ-009 clear_overflow  input  1  clears the sticky overflow flag.
REQ-010 aer_valid  output  1  event word available.
REQ-011 aer_ready  input  1  consumer accepts the event.
REQ-012 aer_addr  output  AW  index of the spiking neuron.
REQ-013 aer_ts  output  TS_W  timestep in which the spike occurred.
REQ-014 overflow  output  1  sticky flag: a spike vector was discarded.

Function
REQ-015 ts_cnt (TS_W bits) SHALL increment by 1 on every enable edge, whether or not spikes are present, and SHALL wrap from 2^TS_W-1 to 0.
REQ-016 pending (N bits) and pend_ts SHALL load spikes_in and the pre-increment ts_cnt on an enable edge when pending == 0 at that edge.
REQ-017 On an enable edge with pending != 0 and spikes_in != 0, the block SHALL discard spikes_in, leave pending unchanged and set overflow.
REQ-018 spikes_in == 0 on an enable edge SHALL never set overflow and SHALL never write an event.
REQ-019 Scanner: on each edge where pending != 0 and the FIFO is not full, the block SHALL write {lowest set bit index, pend_ts} into the FIFO and clear that bit in pending. Lowest index goes first.
REQ-020 FIFO full SHALL be evaluated on the pre-edge count; a pop on the same edge SHALL NOT free a slot for a write on that edge.
REQ-021 When full, scanning SHALL stall with pending held. Backpressure alone SHALL never lose events.
REQ-022 aer_valid SHALL equal FIFO not empty. aer_addr and aer_ts SHALL present the head entry and stay stable while aer_valid = 1 and aer_ready = 0.
REQ-023 Pop SHALL occur on an edge where aer_valid and aer_ready are both 1. Push and pop on the same edge SHALL leave the count unchanged.
REQ-024 Latency: with an empty FIFO and aer_ready = 1, the first event of a vector sampled at edge k SHALL have aer_valid = 1 after edge k+1. Each further bit SHALL follow one cycle later.
REQ-025 Events SHALL leave the block in write order, never reordered or duplicated.
REQ-026 clear_overflow SHALL clear overflow on the next edge. If it coincides with a new overflow condition, set SHALL win.

Reset
REQ-027 On a reset edge, ts_cnt, pending, pend_ts, the FIFO pointers and count, and overflow SHALL all go to 0. reset SHALL take priority over enable, the scanner, pop and clear_overflow.
REQ-028 After reset: aer_valid = 0, aer_addr = 0, aer_ts = 0, overflow = 0. Reset mid-operation SHALL drop all pending and queued events.

Structure
REQ-029 Package spike_aer_pkg SHALL hold the default N, TS_W and DEPTH, the AW derivation, and the event word layout {addr, ts}.
REQ-030 The FIFO SHALL be a single sub-module, aer_event_fifo: synchronous, with full/empty/count, parameterised on width and DEPTH.
REQ-031 The lowest-set-bit priority encoder SHALL be a function in spike_aer_pkg, not a separate module.

Verification
REQ-032 Reset; aer_ready = 1; one enable with spikes_in = 4'b1010 -> events (addr 1, ts 0) then (addr 3, ts 0). aer_valid first high after edge k+1. overflow stays 0.
REQ-033 aer_ready = 0; enables with 4'b1111 at ts 0, 1 and 2, spaced 10 cycles apart -> FIFO holds 8 and the third vector stays pending. overflow = 0. On raising aer_ready, 12 events arrive in order: addr 0-3 at ts 0, then ts 1, then ts 2.
REQ-034 Enable with 4'b1111 then enable next cycle with 4'b0001 -> overflow = 1 and the second vector is dropped. The next accepted vector carries ts 2. clear_overflow then gives overflow = 0.
REQ-035 256 enables with spikes_in = 0, then enable with 4'b0100 -> single event (addr 2, ts 0), confirming wrap. No events are emitted before it.
REQ-036 FIFO non-empty with pending != 0; assert reset for one edge -> next cycle aer_valid = 0 and overflow = 0. A following 4'b0001 enable gives the event (addr 0, ts 0).
REQ-037 Full FIFO with aer_ready = 1 and pending != 0 -> no write on the pop edge, write on the following edge. Count stays at or below 8 and no event is lost.
